// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
// Segment patterns are active-low, with segment a..g on bits 0..6.
package seg_pkg;
  localparam int NDIG = 4;

  typedef logic [1:0] scan_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Glyphs 9 down to 0; the leftmost entry of the concatenation lands at index 9.
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10-15 are not BCD digits and are shown as a dash.
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    if (code < 4'd10) seg = SEG_GLYPH[code];
  end
endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with prescaled refresh.
// Includes leading-zero blanking and tear-free display updates at frame boundaries.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV      = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] pcnt;
  scan_idx_t     idx;
  logic          live;
  logic [15:0]   shadow_dig, disp_dig;
  logic [3:0]    shadow_dp, disp_dp;
  logic          tick, wrap;

  logic [NDIG-1:0][6:0] glyph;
  logic [NDIG-1:0]      zero, blank;
  logic                 run;

  assign tick = en && (pcnt == CW'(DIV-1));
  assign wrap = tick && live && (idx == scan_idx_t'(NDIG-1));

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd7seg u_dec (.code(disp_dig[4*g +: 4]), .seg(glyph[g]));
    assign zero[g] = (disp_dig[4*g +: 4] == 4'd0);
  end

  // A digit blanks only if it and every more-significant digit are zero.
  always_comb begin
    blank = '0;
    run   = LZ_BLANK;
    for (int i = NDIG-1; i > 0; i--) begin
      run      = run && zero[i];
      blank[i] = run;
    end
  end

  // The first tick after reset only arms the display, so digit0 gets a full dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      live       <= 1'b0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
      disp_dig   <= '0;
      disp_dp    <= '0;
      frame      <= 1'b0;
      an         <= 4'hF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      if (en) pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        live <= 1'b1;
        if (live) idx <= idx + 1'b1;
      end
      if (load) begin
        shadow_dig <= digits_in;
        shadow_dp  <= dp_in;
      end
      // A load landing on the boundary bypasses the shadow so it is not lost.
      if (wrap) begin
        disp_dig <= load ? digits_in : shadow_dig;
        disp_dp  <= load ? dp_in     : shadow_dp;
      end
      frame <= wrap;
      if (en && live) begin
        an  <= ~(4'b0001 << idx);
        seg <= blank[idx] ? SEG_BLANK : glyph[idx];
        dp  <= ~disp_dp[idx];
      end else begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end
endmodule
